// File: rtl/rob_pkg.sv
// Shared types and branch decode for the reorder buffer.
package rob_pkg;

  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_REG  = 2'd1,
    DST_MEM  = 2'd2
  } dst_type_e;

  localparam logic [5:0] OP_BR_A = 6'b111001;
  localparam logic [5:0] OP_BR_B = 6'b111101;
  localparam logic [5:0] OP_BR_C = 6'b110000;
  localparam logic [5:0] OP_BR_D = 6'b110100;

  function automatic logic is_branch(input logic [5:0] op);
    return (op == OP_BR_A) || (op == OP_BR_B) || (op == OP_BR_C) || (op == OP_BR_D);
  endfunction

endpackage

// File: rtl/rob_ptr.sv
// Wrapping ring pointer; DEPTH is a power of two so natural overflow wraps it.
module rob_ptr #(
  parameter int unsigned TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [TAG_W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   ptr <= '0;
    else if (clr) ptr <= '0;
    else if (inc) ptr <= ptr + TAG_W'(1);
  end

endmodule

// File: rtl/rob_ring.sv
// Circular reorder buffer: tail allocation, CDB writeback, in-order commit, branch flush.
// Optional feature macro: ROB_BRANCH_FLUSH_EN (taken-branch flush at head).
module rob_ring
  import rob_pkg::*;
#(
  parameter int unsigned DEPTH  = 8,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned OP_W   = 6,
  parameter int unsigned TAG_W  = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alloc_valid,
  input  logic [OP_W-1:0]   alloc_op,
  input  logic [DATA_W-1:0] alloc_dst,
  input  logic [1:0]        alloc_dst_type,
  output logic              alloc_ready,
  output logic [TAG_W-1:0]  alloc_tag,
  input  logic              cdb_valid,
  input  logic [TAG_W-1:0]  cdb_tag,
  input  logic [DATA_W-1:0] cdb_data,
  input  logic              cdb_taken,
  output logic              commit_reg_valid,
  output logic [DATA_W-1:0] commit_reg_id,
  output logic [DATA_W-1:0] commit_reg_data,
  output logic              commit_st_valid,
  input  logic              commit_st_ready,
  output logic [DATA_W-1:0] commit_st_addr,
  output logic [DATA_W-1:0] commit_st_data,
  output logic              flush,
  output logic [TAG_W:0]    count,
  output logic              empty
);

  localparam logic [TAG_W:0] FULL_CNT = (TAG_W+1)'(DEPTH);

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_ready;
  logic [OP_W-1:0]   ent_op   [DEPTH];
  logic [DATA_W-1:0] ent_dst  [DEPTH];
  logic [DATA_W-1:0] ent_val  [DEPTH];
  dst_type_e         ent_type [DEPTH];

  logic [TAG_W-1:0]  head;
  logic [TAG_W-1:0]  tail;
  logic [TAG_W:0]    count_next;
  logic              alloc_fire;
  logic              cdb_hit;
  logic              head_hit;
  logic              head_ready;
  logic [DATA_W-1:0] head_val;
  logic              head_taken;
  logic              retire;
  logic              do_flush;
  logic              reg_issue;
  logic              st_issue;

`ifdef ROB_BRANCH_FLUSH_EN
  logic [DEPTH-1:0] ent_taken;
`else
  logic unused_branch;
  assign unused_branch = ^{cdb_taken, ent_op[head]};
`endif

  rob_ptr #(.TAG_W(TAG_W)) u_head (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (retire),
    .clr   (do_flush),
    .ptr   (head)
  );

  rob_ptr #(.TAG_W(TAG_W)) u_tail (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (alloc_fire && !do_flush),
    .clr   (do_flush),
    .ptr   (tail)
  );

  assign alloc_tag = tail;

  // A CDB write landing on the head entry is bypassed so it can commit on the same edge.
  always_comb begin
    alloc_fire = alloc_valid && alloc_ready;
    cdb_hit    = cdb_valid && ent_valid[cdb_tag];
    head_hit   = cdb_hit && (cdb_tag == head);
    head_ready = ent_valid[head] && (ent_ready[head] || head_hit);
    head_val   = head_hit ? cdb_data : ent_val[head];
`ifdef ROB_BRANCH_FLUSH_EN
    head_taken = head_hit ? (is_branch(6'(ent_op[head])) && cdb_taken) : ent_taken[head];
`else
    head_taken = 1'b0;
`endif
    retire    = 1'b0;
    do_flush  = 1'b0;
    reg_issue = 1'b0;
    st_issue  = 1'b0;
    if (commit_st_valid) begin
      retire = commit_st_ready;
    end else if (head_ready) begin
      case (ent_type[head])
        DST_REG: begin
          reg_issue = 1'b1;
          retire    = 1'b1;
        end
        DST_MEM: st_issue = 1'b1;
        default: begin
          if (head_taken) do_flush = 1'b1;
          else            retire   = 1'b1;
        end
      endcase
    end
    if (do_flush) count_next = '0;
    else count_next = count + (TAG_W+1)'(alloc_fire) - (TAG_W+1)'(retire);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid <= '0;
      ent_ready <= '0;
`ifdef ROB_BRANCH_FLUSH_EN
      ent_taken <= '0;
`endif
    end else if (do_flush) begin
      ent_valid <= '0;
    end else begin
      if (cdb_hit) begin
        ent_ready[cdb_tag] <= 1'b1;
`ifdef ROB_BRANCH_FLUSH_EN
        if (is_branch(6'(ent_op[cdb_tag]))) ent_taken[cdb_tag] <= cdb_taken;
`endif
      end
      if (alloc_fire) begin
        ent_valid[tail] <= 1'b1;
        ent_ready[tail] <= 1'b0;
`ifdef ROB_BRANCH_FLUSH_EN
        ent_taken[tail] <= 1'b0;
`endif
      end
      if (retire) ent_valid[head] <= 1'b0;
    end
  end

  // Payload needs no reset: it is only observed through entries whose valid bit is set.
  always_ff @(posedge clk) begin
    if (alloc_fire && !do_flush) begin
      ent_op[tail]   <= alloc_op;
      ent_dst[tail]  <= alloc_dst;
      ent_type[tail] <= dst_type_e'(alloc_dst_type);
    end
    if (cdb_hit && !do_flush) ent_val[cdb_tag] <= cdb_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      commit_reg_valid <= 1'b0;
      commit_reg_id    <= '0;
      commit_reg_data  <= '0;
      commit_st_valid  <= 1'b0;
      commit_st_addr   <= '0;
      commit_st_data   <= '0;
      count            <= '0;
      empty            <= 1'b1;
      alloc_ready      <= 1'b1;
    end else begin
      commit_reg_valid <= reg_issue;
      if (reg_issue) begin
        commit_reg_id   <= ent_dst[head];
        commit_reg_data <= head_val;
      end
      if (st_issue) begin
        commit_st_valid <= 1'b1;
        commit_st_addr  <= ent_dst[head];
        commit_st_data  <= head_val;
      end else if (commit_st_valid && commit_st_ready) begin
        commit_st_valid <= 1'b0;
      end
      count       <= count_next;
      empty       <= (count_next == '0);
      alloc_ready <= (count_next != FULL_CNT);
    end
  end

`ifdef ROB_BRANCH_FLUSH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flush <= 1'b0;
    else        flush <= do_flush;
  end
`else
  assign flush = 1'b0;
`endif

endmodule
